// File: rtl/count_pkg.sv
// count_pkg -- shared constants, types and reference next-state function
// for the modulo-12 up/down counter.
//   WIDTH              : data path width of din/count
//   MODULUS            : number of count states (count in 0..MODULUS-1)
//   count_t            : WIDTH-bit count type
//   no_of_transactions : number of random transactions in the verification environment
//   next_count()       : pure next-state function (count, load, up_down, din)
package count_pkg;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 12;

    typedef logic [WIDTH-1:0] count_t;

    // Verification environment only; the RTL never reads it.
    localparam int no_of_transactions = 500;

    // Load wins over stepping; out-of-range load values collapse to 0 so the
    // count can never leave 0..MODULUS-1.
    function automatic count_t next_count(input count_t cur, input logic load,
                                          input logic up_down, input count_t din);
        count_t nxt;
        if (load)
            nxt = (int'(din) < MODULUS) ? din : '0;
        else if (up_down)
            nxt = (int'(cur) == MODULUS - 1) ? '0 : count_t'(cur + 1'b1);
        else
            nxt = (cur == '0) ? count_t'(MODULUS - 1) : count_t'(cur - 1'b1);
        return nxt;
    endfunction

endpackage

// File: rtl/rtl_counter.sv
// rtl_counter -- loadable up/down modulo-MODULUS counter.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous reset, active HIGH (1 = reset asserted)
//   din     : parallel load value (values >= MODULUS load as 0)
//   load    : 1 = load din on the next rising edge (beats up_down)
//   up_down : step direction, 1 = up, 0 = down
//   count   : registered count, always in 0..MODULUS-1
// Legal configuration: 2 <= MODULUS <= 2**WIDTH.
module rtl_counter #(
    parameter int WIDTH   = count_pkg::WIDTH,
    parameter int MODULUS = count_pkg::MODULUS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);
    import count_pkg::*;

    // One extra bit so MODULUS == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;

    // Wrap is an explicit compare against MAXV/0 rather than binary
    // overflow, so states MODULUS..2**WIDTH-1 are unreachable.
    always_comb begin
        nxt = count;
        if (load)
            nxt = ({1'b0, din} < MOD_W) ? din : '0;
        else if (up_down)
            nxt = (count == MAXV) ? '0 : count + 1'b1;
        else
            nxt = (count == '0) ? MAXV : count - 1'b1;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)
            count <= '0;
        else
            count <= nxt;
    end

endmodule

// File: tb/tb_rtl_counter.sv
// tb_rtl_counter -- directed plus randomized self-checking bench for rtl_counter.
module tb_rtl_counter;

    logic       clk;
    logic       resetn;
    logic [3:0] din;
    logic       load;
    logic       up_down;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    rtl_counter dut (
        .clk     (clk),
        .resetn  (resetn),
        .din     (din),
        .load    (load),
        .up_down (up_down),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        checks++;
        assert (count === exp) else begin
            errors++;
            $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
        end
    endtask

    // Apply inputs, take one rising edge, and sample 1 time unit later.
    task automatic step(input logic ld, input logic ud, input logic [3:0] d);
        load = ld; up_down = ud; din = d;
        @(posedge clk);
        #1;
    endtask

    // Independent integer reference model of one clock edge.
    function automatic int model(input int c, input bit ld, input bit ud, input int d);
        if (ld) return (d < 12) ? d : 0;
        if (ud) return (c + 1) % 12;
        return (c + 11) % 12;
    endfunction

    initial begin
        int  m;
        bit  r_rst, r_ld, r_ud;
        int  r_d;

        resetn = 1'b1; load = 1'b0; up_down = 1'b1; din = 4'd0;
        #3;
        chk("reset_initial", 4'd0);
        @(posedge clk); #1;
        chk("reset_held", 4'd0);
        resetn = 1'b0;

        // Async reset between edges from a non-zero count.
        step(1'b1, 1'b0, 4'd7);
        chk("load7", 4'd7);
        #2 resetn = 1'b1;
        #1 chk("async_reset", 4'd0);
        load = 1'b1; din = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_hold", 4'd0);
        end
        resetn = 1'b0;

        // Loads, including out-of-range value.
        step(1'b1, 1'b1, 4'd5);  chk("load5", 4'd5);
        step(1'b1, 1'b0, 4'd11); chk("load11", 4'd11);
        step(1'b1, 1'b1, 4'd14); chk("load14", 4'd0);
        step(1'b1, 1'b0, 4'd15); chk("load15", 4'd0);
        step(1'b1, 1'b1, 4'd12); chk("load12", 4'd0);

        // Up wrap 9 -> 10, 11, 0, 1.
        step(1'b1, 1'b0, 4'd9);  chk("load9", 4'd9);
        step(1'b0, 1'b1, 4'd0);  chk("up10", 4'd10);
        step(1'b0, 1'b1, 4'd3);  chk("up11", 4'd11);
        step(1'b0, 1'b1, 4'd15); chk("up_wrap0", 4'd0);
        step(1'b0, 1'b1, 4'd0);  chk("up1", 4'd1);

        // Down wrap 2 -> 1, 0, 11, 10.
        step(1'b1, 1'b1, 4'd2);  chk("load2", 4'd2);
        step(1'b0, 1'b0, 4'd0);  chk("dn1", 4'd1);
        step(1'b0, 1'b0, 4'd7);  chk("dn0", 4'd0);
        step(1'b0, 1'b0, 4'd0);  chk("dn_wrap11", 4'd11);
        step(1'b0, 1'b0, 4'd0);  chk("dn10", 4'd10);

        // Load beats step.
        step(1'b1, 1'b1, 4'd4);  chk("load4", 4'd4);
        step(1'b1, 1'b0, 4'd8);  chk("prio_load8", 4'd8);

        // Reset beats load.
        load = 1'b1; din = 4'd6; resetn = 1'b1;
        @(posedge clk); #1;
        chk("prio_reset", 4'd0);
        resetn = 1'b0;
        step(1'b0, 1'b0, 4'd0);  chk("after_reset_dn", 4'd11);

        // Random transactions against the reference model.
        m = 11;
        for (int i = 0; i < count_pkg::no_of_transactions; i++) begin
            r_rst = ($urandom_range(0, 24) == 0);
            r_ld  = ($urandom_range(0, 3) == 0);
            r_ud  = 1'($urandom_range(0, 1));
            r_d   = $urandom_range(0, 15);
            resetn = r_rst;
            step(r_ld, r_ud, 4'(r_d));
            m = r_rst ? 0 : model(m, r_ld, r_ud, r_d);
            chk("random", 4'(m));
            checks++;
            assert (count < 4'd12) else begin
                errors++;
                $error("FAIL range: count=%0d expected below 12", count);
            end
        end
        resetn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
